// File: rtl/uart_tx.sv
// ============================================================================
// uart_tx : framed UART transmitter with a one-word holding register (rev 1.0)
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_tx #(
  parameter int WIDTH         = 8,
  parameter int DIVISOR       = 100,
  parameter int STOP_BITS     = 1,
  parameter int LITTLE_ENDIAN = 0
) (
  input  logic             clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_data_valid,
  output logic             o_ready,
  output logic             o_tx,
  output logic             o_busy,
  output logic             o_frame_done
);

  localparam int BAUD_W = $clog2(DIVISOR);
  localparam int BIT_W  = $clog2(WIDTH) + 1;
  localparam logic [BAUD_W-1:0] C_BAUD_LAST = BAUD_W'(DIVISOR - 1);
  localparam logic [BIT_W-1:0]  C_DATA_LAST = BIT_W'(WIDTH - 1);
  localparam logic [BIT_W-1:0]  C_STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [BAUD_W-1:0]  baud_q, baud_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [WIDTH-1:0]   hold_q, hold_d;
  logic               hold_full_q, hold_full_d;
  logic               tx_q, tx_d;

  logic w_accept;
  logic w_baud_wrap;
  logic w_frame_end;

  assign o_ready      = ~hold_full_q & ~i_reset;
  assign w_accept     = i_data_valid & o_ready;
  assign w_baud_wrap  = (baud_q == C_BAUD_LAST);
  assign w_frame_end  = (state_q == S_STOP) && w_baud_wrap && (bit_q == C_STOP_LAST);
  assign o_tx         = tx_q;
  assign o_busy       = (state_q != S_IDLE) | hold_full_q;
  assign o_frame_done = w_frame_end;

  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    tx_d        = 1'b1;

    if (state_q != S_IDLE) begin
      baud_d = w_baud_wrap ? '0 : baud_q + BAUD_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          shift_d = i_data;
          baud_d  = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (w_baud_wrap) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (w_baud_wrap) begin
          if (bit_q == C_DATA_LAST) begin
            state_d = S_STOP;
            bit_d   = '0;
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            shift_d = (LITTLE_ENDIAN != 0) ? (shift_q >> 1) : (shift_q << 1);
          end
        end
      end
      S_STOP: begin
        if (w_frame_end) begin
          // An accept landing on the closing edge with an empty hold goes
          // straight to the shifter so the hold never outlives the frame.
          if (hold_full_q) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
            state_d     = S_START;
          end else if (w_accept) begin
            shift_d = i_data;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
          bit_d = '0;
        end else if (w_baud_wrap) begin
          bit_d = bit_q + BIT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (w_accept && (state_q != S_IDLE) && !w_frame_end) begin
      hold_d      = i_data;
      hold_full_d = 1'b1;
    end

    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = (LITTLE_ENDIAN != 0) ? shift_d[0] : shift_d[WIDTH-1];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_q     <= S_IDLE;
      baud_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      tx_q        <= 1'b1;
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      tx_q        <= tx_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx.sv
// ============================================================================
// tb_uart_tx : directed bench for uart_tx (MSB/LSB, two stop bits) (rev 1.0)
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_tx;

  logic       clk = 1'b0;
  logic       i_reset;
  logic [7:0] data;
  logic       valid [3];
  logic       tx    [3];
  logic       rdy   [3];
  logic       busy  [3];
  logic       fd    [3];

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] words [0:255];
  logic       txs   [0:10299];
  logic       rdys  [0:10299];
  logic       busys [0:10299];
  logic       fds   [0:10299];

  always #5 clk = ~clk;

  uart_tx #(.WIDTH(8), .DIVISOR(4), .STOP_BITS(1), .LITTLE_ENDIAN(0)) u_msb (
    .clk(clk), .i_reset(i_reset), .i_data(data), .i_data_valid(valid[0]),
    .o_ready(rdy[0]), .o_tx(tx[0]), .o_busy(busy[0]), .o_frame_done(fd[0]));

  uart_tx #(.WIDTH(8), .DIVISOR(4), .STOP_BITS(1), .LITTLE_ENDIAN(1)) u_lsb (
    .clk(clk), .i_reset(i_reset), .i_data(data), .i_data_valid(valid[1]),
    .o_ready(rdy[1]), .o_tx(tx[1]), .o_busy(busy[1]), .o_frame_done(fd[1]));

  uart_tx #(.WIDTH(8), .DIVISOR(4), .STOP_BITS(2), .LITTLE_ENDIAN(0)) u_sb2 (
    .clk(clk), .i_reset(i_reset), .i_data(data), .i_data_valid(valid[2]),
    .o_ready(rdy[2]), .o_tx(tx[2]), .o_busy(busy[2]), .o_frame_done(fd[2]));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Hold valid on unit u, feeding words[0..nw-1]; record one sample per cycle.
  // Cycle c is the interval following rising edge c; edge 0 is the first accept.
  task automatic stream(input int u, input int nw, input int ncyc);
    int   wi;
    logic acc;
    wi = 0;
    data = words[0];
    valid[u] = 1'b1;
    for (int c = 0; c < ncyc; c++) begin
      acc = valid[u] && rdy[u];
      @(negedge clk);
      if (acc) begin
        wi++;
        if (wi < nw) data = words[wi];
        else begin
          valid[u] = 1'b0;
          data = ~data;
        end
      end
      txs[c] = tx[u]; rdys[c] = rdy[u]; busys[c] = busy[u]; fds[c] = fd[u];
    end
  endtask

  function automatic logic [15:0] frame_bits(input int st, input int n);
    logic [15:0] r;
    r = '0;
    for (int b = 0; b < n; b++) r = {r[14:0], txs[st + 4*b + 2]};
    return r;
  endfunction

  function automatic int cnt_busy(input int a, input int b);
    int n;
    n = 0;
    for (int i = a; i <= b; i++) if (busys[i]) n++;
    return n;
  endfunction

  function automatic int cnt_fd(input int a, input int b);
    int n;
    n = 0;
    for (int i = a; i <= b; i++) if (fds[i]) n++;
    return n;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [39:0] obs40, exp40;
    logic [9:0]  exp10;
    logic [7:0]  stopv;
    int          bad;

    i_reset = 1'b1;
    data = 8'h00;
    for (int i = 0; i < 3; i++) valid[i] = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_ready", {rdy[0], rdy[1], rdy[2]}, 3'b000);
    check("reset_tx",    {tx[0], tx[1], tx[2]}, 3'b111);
    check("reset_busy",  {busy[0], busy[1], busy[2]}, 3'b000);
    check("reset_fdone", {fd[0], fd[1], fd[2]}, 3'b000);
    i_reset = 1'b0;
    @(negedge clk);
    check("post_reset_ready", {rdy[0], rdy[1], rdy[2]}, 3'b111);

    // Single MSB-first 0xA5, exact cycle-level waveform
    words[0] = 8'hA5;
    stream(0, 1, 42);
    exp10 = 10'b0101001011;
    for (int c = 0; c < 40; c++) begin
      obs40[39-c] = txs[c];
      exp40[39-c] = exp10[9 - c/4];
    end
    check("msb_a5_wave",      obs40, exp40);
    check("msb_a5_fd_count",  cnt_fd(0, 41), 1);
    check("msb_a5_fd_cycle",  fds[39], 1'b1);
    check("msb_a5_busy",      cnt_busy(0, 39), 40);
    check("msb_a5_idle",      {txs[40], busys[40], fds[40]}, 3'b100);

    // LSB-first words
    words[0] = 8'hA5;
    stream(1, 1, 42);
    check("lsb_a5_bits", frame_bits(0, 10), 10'b0101001011);
    check("lsb_a5_busy", cnt_busy(0, 41), 40);
    check("lsb_a5_fd",   {fds[39], cnt_fd(0, 41) == 1}, 2'b11);
    words[0] = 8'h01;
    stream(1, 1, 42);
    check("lsb_01_bits", frame_bits(0, 10), 10'b0100000001);
    check("lsb_01_idle", {txs[40], busys[40]}, 2'b10);

    // Back-to-back with backpressure
    words[0] = 8'h01; words[1] = 8'h02; words[2] = 8'h03;
    stream(0, 3, 122);
    check("b2b_ready", {rdys[0], rdys[1], rdys[39], rdys[40], rdys[41]}, 5'b10010);
    check("b2b_frame1", frame_bits(0, 10),  10'b0000000011);
    check("b2b_frame2", frame_bits(40, 10), 10'b0000000101);
    check("b2b_frame3", frame_bits(80, 10), 10'b0000000111);
    check("b2b_starts", {txs[40], txs[80]}, 2'b00);
    check("b2b_busy",   cnt_busy(0, 121), 120);
    check("b2b_fd",     {fds[39], fds[79], fds[119], cnt_fd(0, 121) == 3}, 4'b1111);
    check("b2b_idle",   {txs[120], busys[120]}, 2'b10);

    // Two stop bits
    words[0] = 8'h3C; words[1] = 8'hC3;
    stream(2, 2, 92);
    check("sb2_frame1", frame_bits(0, 11), 11'b00011110011);
    for (int c = 36; c < 44; c++) stopv[c-36] = txs[c];
    check("sb2_stop_len", {stopv, txs[44]}, 9'b111111110);
    check("sb2_frame2", frame_bits(44, 11), 11'b01100001111);
    check("sb2_fd",     {fds[43], fds[87], cnt_fd(0, 91) == 2}, 3'b111);
    check("sb2_busy",   cnt_busy(0, 91), 88);

    // Reset during data bit 3 with a word in hold
    data = 8'h4A;
    valid[0] = 1'b1;
    @(negedge clk);
    data = 8'h33;
    @(negedge clk);
    valid[0] = 1'b0;
    check("rst_hold_full", {rdy[0], busy[0]}, 2'b01);
    repeat (16) @(negedge clk);
    check("rst_pre_bit3", tx[0], 1'b0);
    i_reset = 1'b1;
    #1;
    check("rst_ready_comb", rdy[0], 1'b0);
    @(negedge clk);
    check("rst_edge", {tx[0], busy[0], fd[0], rdy[0]}, 4'b1000);
    i_reset = 1'b0;
    @(negedge clk);
    check("rst_release", {tx[0], busy[0], rdy[0]}, 3'b101);
    bad = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (!tx[0] || busy[0] || fd[0]) bad++;
    end
    check("rst_no_frame", bad, 0);

    // 256 sequential bytes, decoded from the line
    for (int i = 0; i < 256; i++) words[i] = 8'(i);
    stream(0, 256, 256*40 + 2);
    bad = 0;
    for (int f = 0; f < 256; f++)
      if (frame_bits(40*f, 10) != {1'b0, 8'(f), 1'b1}) bad++;
    check("loop_mismatches", bad, 0);
    check("loop_fd_count",   cnt_fd(0, 256*40 + 1), 256);
    check("loop_idle",       {txs[10240], busys[10240]}, 2'b10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
